// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: WIDTH-bit, DEPTH-stage register pipeline with per-stage
// valid bits and a valid/ready handshake. An empty stage accepts data even
// while the stages below it are stalled.
// Optional build macro PIPE_REG_CHAIN_PARITY_EN adds a per-stage even-parity
// bit, an inj_perr input and a live out_perr; without it out_perr is 0.
module pipe_reg_chain #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
`ifdef PIPE_REG_CHAIN_PARITY_EN
  input  logic                         inj_perr,
`endif
  output logic                         out_perr
);

  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] up_vld;
  logic [WIDTH-1:0] up_data [DEPTH];

  // Stage ready: written in closed form (downstream ready, or any empty stage
  // at or below this one) so the chain has no self-referencing vector.
  always_comb begin
    logic full_tail;
    rdy        = '0;
    full_tail  = 1'b1;
    rdy[DEPTH] = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      full_tail = 1'b1;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j >= i) full_tail = full_tail & vld_q[j];
      end
      rdy[i] = out_ready | ~full_tail;
    end
  end

  // Upstream source of each stage: the input port for stage 0, else the previous stage.
  always_comb begin
    up_vld     = '0;
    up_vld[0]  = in_valid;
    up_data[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      up_vld[i]  = vld_q[i-1];
      up_data[i] = data_q[i-1];
    end
  end

  // Pipeline registers: reset, flush of valid bits, or per-stage advance/hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= RST_VAL;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          vld_q[i] <= up_vld[i];
          if (up_vld[i]) data_q[i] <= up_data[i];
        end
      end
    end
  end

  // Occupancy is a popcount of the registered valid bits only.
  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(vld_q[i]);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_REG_CHAIN_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic [DEPTH-1:0] up_par;

  // Parity source: generated from in_data at stage 0 (optionally inverted), carried thereafter.
  always_comb begin
    up_par    = '0;
    up_par[0] = (^in_data) ^ inj_perr;
    for (int unsigned i = 1; i < DEPTH; i++) up_par[i] = par_q[i-1];
  end

  // Parity bits move in lock-step with the data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= '0;
    end else if (!flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rdy[i] && up_vld[i]) par_q[i] <= up_par[i];
      end
    end
  end

  assign out_perr = vld_q[DEPTH-1] & ((^data_q[DEPTH-1]) != par_q[DEPTH-1]);
`else
  assign out_perr = 1'b0;
`endif

endmodule
